// File: rtl/fft_iter_pkg.sv
// Shared definitions for the iterative FFT front end:
// FSM state encoding and the address bit-reversal helper.
package fft_iter_pkg;

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] KICK    = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    ST_LOAD    = LOAD,
    ST_KICK    = KICK,
    ST_WAIT_HI = WAIT_HI,
    ST_WAIT_LO = WAIT_LO
  } ld_state_e;

  // Reverse the low awl bits of v; bits above awl come back zero.
  function automatic int bit_reverse(input int v, input int awl);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < awl) r[awl-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// Streaming sample loader: packs sample pairs into dual-port
// writes of the FFT core's input RAM and kicks the core per frame.
module fft_frame_loader
  import fft_iter_pkg::*;
#(
  parameter int IWL     = 32,
  parameter int AWL     = 5,
  parameter int BIT_REV = 0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [IWL-1:0] i_DATA,
  input  logic           i_VALID,
  output logic           o_READY,
  input  logic           i_RAM_BLOCK,
  output logic [IWL-1:0] o_A_DATA,
  output logic [IWL-1:0] o_B_DATA,
  output logic [AWL-1:0] o_A_ADDR,
  output logic [AWL-1:0] o_B_ADDR,
  output logic           o_RAM_Wr,
  output logic           o_START,
  output logic           o_BUSY
);

  ld_state_e      state_q, state_d;
  logic [AWL-1:0] cnt_q, cnt_d;
  logic [IWL-1:0] hold_q, hold_d;
  logic [IWL-1:0] a_data_q, a_data_d;
  logic [IWL-1:0] b_data_q, b_data_d;
  logic [AWL-1:0] a_addr_q, a_addr_d;
  logic [AWL-1:0] b_addr_q, b_addr_d;
  logic           wr_q, wr_d;
  logic           ready;
  logic           hs;
  logic [AWL-1:0] idx_a, idx_b;
  logic [AWL-1:0] map_a, map_b;

  assign ready = !RST && EN && (state_q == ST_LOAD)
              && !i_RAM_BLOCK;
  assign hs    = ready && i_VALID;

  assign idx_a = cnt_q - 1'b1;
  assign idx_b = cnt_q;

  always_comb begin
    map_a = idx_a;
    map_b = idx_b;
    if (BIT_REV != 0) begin
      map_a = AWL'(bit_reverse(int'(idx_a), AWL));
      map_b = AWL'(bit_reverse(int'(idx_b), AWL));
    end
  end

  // A pending write survives an EN-low gap and is presented once EN returns.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    wr_d     = wr_q;
    if (EN) begin
      wr_d = 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          if (hs) begin
            cnt_d = cnt_q + 1'b1;
            if (!cnt_q[0]) begin
              hold_d = i_DATA;
            end else begin
              a_data_d = hold_q;
              b_data_d = i_DATA;
              a_addr_d = map_a;
              b_addr_d = map_b;
              wr_d     = 1'b1;
            end
            if (&cnt_q) state_d = ST_KICK;
          end
        end
        ST_KICK: begin
          state_d = ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (i_RAM_BLOCK) state_d = ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!i_RAM_BLOCK) state_d = ST_LOAD;
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      hold_q   <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      wr_q     <= wr_d;
    end
  end

  assign o_READY  = ready;
  assign o_A_DATA = a_data_q;
  assign o_B_DATA = b_data_q;
  assign o_A_ADDR = a_addr_q;
  assign o_B_ADDR = b_addr_q;
  assign o_RAM_Wr = EN && wr_q;
  assign o_START  = !RST && EN && (state_q == ST_KICK);
  assign o_BUSY   = (state_q != ST_LOAD);

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: natural and bit-reversed instances
// share one stimulus; writes are checked against a scoreboard.
module tb_fft_frame_loader;

  typedef struct packed {
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [31:0] ad;
    logic [31:0] bd;
  } wr_t;

  typedef struct {
    logic v;
    logic b;
    logic rdy;
    logic wr;
    logic st;
    logic busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic valid = 1'b0;
  logic blk = 1'b0;
  logic [31:0] data = '0;

  logic rdy0, rdy1, wr0, wr1, st0, st1, bz0, bz1;
  logic [31:0] ad0, bd0, ad1, bd1;
  logic [2:0] aa0, ba0, aa1, ba1;

  int ntests = 0;
  int nfail = 0;
  int nstart = 0;
  int nwr0 = 0;
  int nwr1 = 0;
  int mcnt = 0;
  int sidx = 0;
  logic [31:0] mhold = '0;
  wr_t q0[$];
  wr_t q1[$];
  logic [2:0] br [8] = '{3'd0, 3'd4, 3'd2, 3'd6,
                         3'd1, 3'd5, 3'd3, 3'd7};
  vec_t tbl[30];

  always #5 clk = ~clk;

  fft_frame_loader #(.IWL(32), .AWL(3), .BIT_REV(0)) u_nat (
    .CLK(clk), .RST(rst), .EN(en),
    .i_DATA(data), .i_VALID(valid), .o_READY(rdy0),
    .i_RAM_BLOCK(blk),
    .o_A_DATA(ad0), .o_B_DATA(bd0),
    .o_A_ADDR(aa0), .o_B_ADDR(ba0),
    .o_RAM_Wr(wr0), .o_START(st0), .o_BUSY(bz0)
  );

  fft_frame_loader #(.IWL(32), .AWL(3), .BIT_REV(1)) u_rev (
    .CLK(clk), .RST(rst), .EN(en),
    .i_DATA(data), .i_VALID(valid), .o_READY(rdy1),
    .i_RAM_BLOCK(blk),
    .o_A_DATA(ad1), .o_B_DATA(bd1),
    .o_A_ADDR(aa1), .o_B_ADDR(ba1),
    .o_RAM_Wr(wr1), .o_START(st1), .o_BUSY(bz1)
  );

  function automatic logic [31:0] mk(input int k);
    return {16'(k), 16'(k)};
  endfunction

  function void chk(input string nm,
                    input logic [69:0] act,
                    input logic [69:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Runs at the negedge: pops writes, then updates the reference model.
  function void mon();
    wr_t e;
    if (wr0) begin
      nwr0++;
      if (q0.size() == 0) chk("wr_nat_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("wr_nat", {aa0, ba0, ad0, bd0}, e);
      end
    end
    if (wr1) begin
      nwr1++;
      if (q1.size() == 0) chk("wr_rev_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("wr_rev", {aa1, ba1, ad1, bd1}, e);
      end
    end
    if (st0) nstart++;
    if (rst) begin
      mcnt = 0;
    end else if (rdy0 && valid) begin
      if (mcnt % 2 == 1) begin
        q0.push_back('{3'(mcnt-1), 3'(mcnt), mhold, data});
        q1.push_back('{br[mcnt-1], br[mcnt], mhold, data});
      end else begin
        mhold = data;
      end
      mcnt = (mcnt + 1) % 8;
      sidx++;
    end
  endfunction

  task automatic set_at(input logic v, input logic b,
                        input logic e, input logic r);
    valid = v;
    blk   = b;
    en    = e;
    rst   = r;
    data  = mk(sidx);
    @(negedge clk);
    mon();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic b,
                     input logic e, input logic r);
    set_at(v, b, e, r);
    nxt();
  endtask

  task automatic release_core();
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    set_at(0, 0, 1, 0);
    chk("rel_ready", rdy0, 1);
    chk("rel_busy", bz0, 0);
    nxt();
  endtask

  task automatic feed_frame(input string nm);
    int s0;
    s0 = sidx;
    for (int i = 0; i < 200 && sidx - s0 < 8; i++) begin
      cyc(1'($urandom_range(0, 1)), 0, 1, 0);
    end
    chk({nm, "_feed_done"}, sidx - s0, 8);
  endtask

  initial begin
    int st_base;
    int blk_left;
    int s0;
    logic blk_done;

    for (int c = 0; c < 30; c++) begin
      tbl[c] = '{v: 0, b: 0, rdy: 0, wr: 0, st: 0, busy: 1};
      if (c < 8) begin
        tbl[c].v = 1;
        tbl[c].rdy = 1;
        tbl[c].busy = 0;
        tbl[c].wr = (c == 2 || c == 4 || c == 6);
      end
      if (c == 8) begin
        tbl[c].wr = 1;
        tbl[c].st = 1;
      end
      if (c >= 11 && c <= 27) tbl[c].b = 1;
      if (c == 29) begin
        tbl[c].rdy = 1;
        tbl[c].busy = 0;
      end
    end

    rst = 1;
    valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy0, 0);
    chk("rst_wr", wr0, 0);
    chk("rst_start", st0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_addr", {aa0, ba0, aa1, ba1}, 0);
    chk("rst_data", {ad0, bd0}, 0);
    nxt();

    // Gap-free frame, then core handshake: block +3..+19, low at +20.
    for (int c = 0; c < 30; c++) begin
      set_at(tbl[c].v, tbl[c].b, 1, 0);
      chk($sformatf("t%0d_ready", c), {rdy0, rdy1},
          {tbl[c].rdy, tbl[c].rdy});
      chk($sformatf("t%0d_wr", c), {wr0, wr1},
          {tbl[c].wr, tbl[c].wr});
      chk($sformatf("t%0d_start", c), {st0, st1},
          {tbl[c].st, tbl[c].st});
      chk($sformatf("t%0d_busy", c), {bz0, bz1},
          {tbl[c].busy, tbl[c].busy});
      nxt();
    end

    // Random valid gaps with a 5-cycle block mid-frame.
    st_base = nstart;
    s0 = sidx;
    blk_left = 0;
    blk_done = 0;
    for (int i = 0; i < 300 && sidx - s0 < 8; i++) begin
      if (!blk_done && mcnt == 3) begin
        blk_left = 5;
        blk_done = 1;
      end
      set_at(1'($urandom_range(0, 1)), blk_left > 0, 1, 0);
      if (blk_left > 0) begin
        chk("blk_ready", rdy0, 0);
        blk_left--;
      end
      nxt();
    end
    chk("gap_feed_done", sidx - s0, 8);
    chk("gap_blocked", blk_done, 1);
    set_at(0, 0, 1, 0);
    chk("gap_start", st0, 1);
    nxt();
    release_core();
    chk("gap_nstart", nstart - st_base, 1);

    // Reset after 5 samples discards the partial frame.
    st_base = nstart;
    repeat (5) cyc(1, 0, 1, 0);
    set_at(1, 0, 1, 1);
    chk("mid_rst_ready", rdy0, 0);
    nxt();
    set_at(0, 0, 1, 0);
    chk("post_rst_regs", {aa0, ba0, ad0, bd0, wr0}, 0);
    chk("post_rst_busy", bz0, 0);
    nxt();
    chk("rst_nostart", nstart - st_base, 0);
    feed_frame("rst");
    cyc(0, 0, 1, 0);
    chk("rst_frame_start", nstart - st_base, 1);
    release_core();

    // EN low for 4 cycles mid-frame.
    st_base = nstart;
    repeat (3) cyc(1, 0, 1, 0);
    s0 = sidx;
    repeat (4) begin
      set_at(1, 0, 0, 0);
      chk("en_ready", rdy0, 0);
      chk("en_wr", {wr0, wr1}, 0);
      chk("en_start", st0, 0);
      nxt();
    end
    chk("en_no_hs", sidx - s0, 0);
    s0 = sidx;
    for (int i = 0; i < 200 && sidx - s0 < 5; i++) begin
      cyc(1, 0, 1, 0);
    end
    chk("en_feed_done", sidx - s0, 5);
    cyc(0, 0, 1, 0);
    chk("en_frame_start", nstart - st_base, 1);
    release_core();

    chk("q_nat_empty", q0.size(), 0);
    chk("q_rev_empty", q1.size(), 0);
    chk("nwr_nat", nwr0, 18);
    chk("nwr_rev", nwr1, 18);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
